// File: rtl/game_sequencer.sv
// Unicorn Explosion game controller: tick generator, IDLE/RUN/DEAD FSM, map scroll, jump timer, score and level.
// tick/map_req are decoded from registered state; map, score and airborne update on the tick edge.
module game_sequencer #(
    parameter int TICK_DIV    = 100_000,
    parameter int JUMP_TICKS  = 3,
    parameter int LEVEL_SHIFT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        jump_btn,
    input  logic [1:0]  map_in,
    output logic        map_req,
    output logic [15:0] map_tiles,
    output logic        tick,
    output logic        airborne,
    output logic        is_dead,
    output logic [15:0] score,
    output logic [1:0]  level,
    output logic [1:0]  state
);
    localparam int               CNT_W     = $clog2(TICK_DIV + 1);
    localparam logic [CNT_W-1:0] DIV       = CNT_W'(TICK_DIV);
    localparam logic [3:0]       JUMP_LOAD = 4'(JUMP_TICKS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [3:0]       jcnt_q, jcnt_d;
    logic             air_q, air_d;
    logic             jump_q;
    logic [15:0]      map_q, map_d;
    logic [15:0]      score_q, score_d;
    logic [1:0]       level_q, level_d;

    logic             tick_w;
    logic             jump_edge;
    logic             fatal;
    logic [1:0]       tile0;
    logic [15:0]      lvl_raw;
    logic [1:0]       level_sat;

    always_comb begin
        tile0     = map_q[15:14];
        tick_w    = (state_q == RUN) && (cnt_q == period_q - CNT_W'(1));
        jump_edge = jump_btn && !jump_q;
        // Collision is judged on the airborne flag as it stood at the start of the tick cycle.
        fatal     = tick_w && (((tile0 == 2'd1) && !air_q) || ((tile0 == 2'd2) && air_q));
        lvl_raw   = score_q >> LEVEL_SHIFT;
        level_sat = (lvl_raw > 16'd3) ? 2'd3 : lvl_raw[1:0];

        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        jcnt_d   = jcnt_q;
        air_d    = air_q;
        map_d    = map_q;
        score_d  = score_q;
        level_d  = level_sat;
        map_req  = 1'b0;

        case (state_q)
            IDLE, DEAD: begin
                if (start) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    period_d = DIV;
                    jcnt_d   = '0;
                    air_d    = 1'b0;
                    map_d    = '0;
                    score_d  = '0;
                    level_d  = 2'd0;
                end
            end
            RUN: begin
                cnt_d = tick_w ? '0 : cnt_q + CNT_W'(1);
                // The period is latched at reload so a level change never truncates a running count.
                if (tick_w) begin
                    period_d = DIV >> level_q;
                end
                if (fatal) begin
                    state_d = DEAD;
                end else begin
                    if (tick_w) begin
                        map_req = 1'b1;
                        map_d   = {map_q[13:0], map_in};
                        if (air_q) begin
                            if ((tile0 == 2'd1) && (score_q != 16'hFFFF)) begin
                                score_d = score_q + 16'd1;
                            end
                            jcnt_d = jcnt_q - 4'd1;
                            if (jcnt_q == 4'd1) begin
                                air_d = 1'b0;
                            end
                        end
                    end
                    if (jump_edge && !air_q) begin
                        air_d  = 1'b1;
                        jcnt_d = JUMP_LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= DIV;
            jcnt_q   <= '0;
            air_q    <= 1'b0;
            jump_q   <= 1'b0;
            map_q    <= '0;
            score_q  <= '0;
            level_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            jcnt_q   <= jcnt_d;
            air_q    <= air_d;
            jump_q   <= jump_btn;
            map_q    <= map_d;
            score_q  <= score_d;
            level_q  <= level_d;
        end
    end

    assign tick      = tick_w;
    assign map_tiles = map_q;
    assign airborne  = air_q;
    assign is_dead   = (state_q == DEAD);
    assign score     = score_q;
    assign level     = level_q;
    assign state     = state_q;

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game controller for Unicorn Explosion. It generates the game tick and runs the IDLE/RUN/DEAD state machine. It scrolls the 8-tile map register and sequences the jump and airborne timer. At each tick it resolves the player-tile collision and maintains the score and speed level. It sits between the button debouncers and map tile generator on the input side, and the VGA/score display on the output side.

## Interface
- `TICK_DIV`, 100_000: clk cycles per game tick at speed level 0; must be ≥ 8.
- `JUMP_TICKS`, 3: ticks the player stays airborne per jump, range 1–15.
- `LEVEL_SHIFT`, 4: level = score >> LEVEL_SHIFT, saturating at 3.
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: start/restart request, level-sampled, already synchronous.
- `jump_btn` in 1: debounced jump button, synchronous; action on rising edge.
- `map_in` in 2: next tile entering at the right; 0 empty, 1 low block, 2 high block, 3 reserved.
- `map_req` out 1: one-cycle pulse; `map_in` is consumed this cycle and the generator advances.
- `map_tiles` out 16: tile 0 at [15:14] is the player position; tile 7 at [1:0].
- `tick` out 1: one-cycle pulse per game tick.
- `airborne` out 1: player is in the air.
- `is_dead` out 1: high in DEAD.
- `score` out 16: low blocks cleared, saturating at 0xFFFF.
- `level` out 2: current speed level.
- `state` out 2: 0 IDLE, 1 RUN, 2 DEAD.

## Operation
- **States:**
  - IDLE: `start` → RUN.
  - RUN: a fatal collision → DEAD.
  - DEAD: `start` → RUN.
  - `start` while in RUN is ignored. State 3 is unreachable and recovers to IDLE.
- **Entering RUN** (from IDLE or DEAD), on the same edge:
  - clear `map_tiles`, `score`, `airborne`, jump counter and tick counter.
  - `level` becomes 0.
- **Tick counter:** runs only in RUN. Period P = `TICK_DIV` >> `level`. When count = P−1, `tick` pulses and the counter reloads to 0. A level change takes effect from the next reload.
- **Jump edge detect:** register `jump_btn` every cycle. A rising edge in RUN with `airborne` = 0 sets `airborne` = 1 and jump counter = `JUMP_TICKS`. Edges while airborne, in IDLE, or in DEAD are ignored.
- **On a tick cycle,** using `airborne` and `map_tiles` as registered at the start of the cycle, let tile T = `map_tiles`[15:14]:
  - T = 1 and not airborne: dead.
  - T = 2 and airborne: dead.
  - T = 1 and airborne: `score` +1, saturating.
  - T = 0 or 3: no effect.
- **If the tick is not fatal:**
  - `map_tiles` ← {`map_tiles`[13:0], `map_in`}, and `map_req` pulses in the same cycle.
  - If airborne, decrement the jump counter; at 0, clear `airborne`.
- **If the tick is fatal:** enter DEAD. The map, score and `airborne` freeze; no `map_req` is issued.
- **Jump edge and tick in the same cycle:** collision uses the old `airborne` = 0. The new jump loads `JUMP_TICKS` with no decrement this tick.
- **Level:** `level` = min(`score` >> `LEVEL_SHIFT`, 3), registered, updated the cycle after `score` changes.

## Timing
- **Reset values:** all outputs 0; state IDLE; internal counters 0; the registered `jump_btn` is 0.
- **First tick:** fires `TICK_DIV` cycles after the edge that enters RUN; subsequent ticks follow every P cycles.
- **`tick` / `map_req`:** each is exactly 1 cycle wide, and `map_req` is coincident with `tick`.
- **`score` / `map_tiles` / `airborne`:** update on the tick edge, visible the cycle after `tick` is high.
- **`is_dead`:** goes high the cycle after the fatal tick, together with `state` = DEAD.
- **Reset mid-RUN:** returns to IDLE on the next edge regardless of pending tick or jump.

## Test plan
1. **Start and scroll:** `TICK_DIV`=8, `map_in` held at 0, pulse `start`.
   - Expected: first `tick` 8 cycles later, then every 8 cycles; `map_req` coincident; `map_tiles` stays 0; `state`=1.
2. **Load a low block:** feed `map_in`=1 once, then 0.
   - Expected: after 8 ticks `map_tiles`[15:14]=1.
   - Without a jump, the next tick gives `is_dead`=1, `state`=2, and `map_tiles` frozen at 0x4000.
3. **Jump over low block:** with `JUMP_TICKS`=3, pulse `jump_btn` one cycle before the tick where T=1.
   - Expected: `score`=1; `airborne` clears after the 3rd tick; a second press while airborne is ignored.
4. **High block while airborne:** T=2 while `airborne`=1.
   - Expected: dead. The same block while grounded passes with `score` unchanged.
5. **Level-up:** `LEVEL_SHIFT`=1, `TICK_DIV`=16; clear 2 low blocks.
   - Expected: `level`=1 and the tick period becomes 8; after 6 blocks `level` stays 3 with period 2.
6. **Restart and reset:**
   - `start` in DEAD → RUN with `score`=0 and the map cleared.
   - `rst_n`=0 for one cycle mid-RUN gives all outputs 0 and `state`=0.
   - A jump edge coincident with a fatal-T=1 tick still kills the player.
